// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit producing HI/LO write traffic.
//   MULT/MULTU   pipelined multiply, result written MUL_LAT cycles after accept
//   DIV/DIVU     radix-2 restoring divider, result written 34 cycles after accept
//   MTHI/MTLO    direct write one cycle after accept, never stalls
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   op_valid, op         request and opcode (0..5 valid), sampled when !busy
//   src_a, src_b         operands, latched at accept
//   flush                cancels in-flight op, masks wen combinationally
//   busy                 MUL/DIV in flight
//   wen                  {write HI, write LO}, one-cycle pulse
//   hiwdata, lowdata     write data; unwritten side holds its last value
module muldiv_unit #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic [1:0]  wen,
  output logic [31:0] hiwdata,
  output logic [31:0] lowdata
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_WB} state_t;

  localparam logic [5:0] MUL_LAST = (MUL_LAT >= 2) ? 6'(MUL_LAT - 2) : 6'd0;

  state_t      r_state, w_state_nx;
  logic [5:0]  r_cnt;
  logic        r_mt, r_signed, r_neg_q, r_neg_r, r_dz;
  logic [31:0] r_a, r_b, r_rem, r_quo;
  logic [1:0]  r_wen;
  logic [31:0] r_hi, r_lo;

  logic        w_busy, w_accept, w_msgn, w_sa, w_sb, w_ge;
  logic [31:0] w_ma, w_mb, w_diff, w_q_fix, w_r_fix;
  logic [63:0] w_mx, w_my, w_prod;
  logic [32:0] w_shift;

  always_comb begin
    // The WB cycle of an MT op is not a stall, so back-to-back MTs are accepted.
    w_busy   = (r_state == S_MUL) || (r_state == S_DIV) || ((r_state == S_WB) && !r_mt);
    w_accept = op_valid && !w_busy && !flush && (op <= 3'd5);

    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_WB: begin
        w_state_nx = S_IDLE;
        if (w_accept) begin
          case (op)
            3'd0, 3'd1: w_state_nx = (MUL_LAT == 1) ? S_WB : S_MUL;
            3'd2, 3'd3: w_state_nx = S_DIV;
            default:    w_state_nx = S_WB;
          endcase
        end
      end
      S_MUL:   if (r_cnt == MUL_LAST) w_state_nx = S_WB;
      S_DIV:   if (r_cnt == 6'd32) w_state_nx = S_WB;
      default: w_state_nx = S_IDLE;
    endcase
    if (flush) w_state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  // Multiplier operands come straight from the ports on the accept cycle so
  // MUL_LAT=1 can write at the accept edge; otherwise from the latched copy.
  always_comb begin
    w_ma   = w_accept ? src_a : r_a;
    w_mb   = w_accept ? src_b : r_b;
    w_msgn = w_accept ? (op == 3'd0) : r_signed;
    w_mx   = {{32{w_msgn & w_ma[31]}}, w_ma};
    w_my   = {{32{w_msgn & w_mb[31]}}, w_mb};
    w_prod = w_mx * w_my;
  end

  always_comb begin
    w_sa    = (op == 3'd2) && src_a[31];
    w_sb    = (op == 3'd2) && src_b[31];
    w_shift = {r_rem, r_quo[31]};
    w_ge    = (w_shift >= {1'b0, r_b});
    w_diff  = w_shift[31:0] - r_b;
    w_q_fix = r_neg_q ? -r_quo : r_quo;
    w_r_fix = r_neg_r ? -r_rem : r_rem;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_mt     <= 1'b0;
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_wen    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_wen <= '0;
      r_cnt <= r_cnt + 6'd1;
      if (w_accept) begin
        r_cnt <= '0;
        r_mt  <= op[2];
        case (op)
          3'd0, 3'd1: begin
            r_a      <= src_a;
            r_b      <= src_b;
            r_signed <= (op == 3'd0);
            if (MUL_LAT == 1) begin
              r_wen <= 2'b11;
              r_hi  <= w_prod[63:32];
              r_lo  <= w_prod[31:0];
            end
          end
          3'd2, 3'd3: begin
            // Setup folded into accept: divide magnitudes, fix signs at the end.
            r_a     <= src_a;
            r_b     <= w_sb ? -src_b : src_b;
            r_quo   <= w_sa ? -src_a : src_a;
            r_rem   <= '0;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_dz    <= (src_b == '0);
          end
          3'd4: begin
            r_wen <= 2'b10;
            r_hi  <= src_a;
          end
          3'd5: begin
            r_wen <= 2'b01;
            r_lo  <= src_a;
          end
          default: ;
        endcase
      end else if (!flush) begin
        case (r_state)
          S_MUL: begin
            if (r_cnt == MUL_LAST) begin
              r_wen <= 2'b11;
              r_hi  <= w_prod[63:32];
              r_lo  <= w_prod[31:0];
            end
          end
          S_DIV: begin
            if (r_cnt == 6'd32) begin
              r_wen <= 2'b11;
              r_hi  <= r_dz ? r_a : w_r_fix;
              r_lo  <= r_dz ? 32'hFFFF_FFFF : w_q_fix;
            end else begin
              r_rem <= w_ge ? w_diff : w_shift[31:0];
              r_quo <= {r_quo[30:0], w_ge};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy    = w_busy;
  assign wen     = flush ? 2'b00 : r_wen;
  assign hiwdata = r_hi;
  assign lowdata = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed cases plus randomized traffic, all
// checked cycle by cycle against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int unsigned MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [1:0]  wen;
  logic [31:0] hiwdata, lowdata;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  muldiv_unit #(.MUL_LAT(MUL_LAT)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .wen      (wen),
    .hiwdata  (hiwdata),
    .lowdata  (lowdata)
  );

  always #5 clk = ~clk;

  // Reference model: one pending write with its due cycle.
  bit          m_pend = 0;
  bit          m_long = 0;
  int unsigned m_due = 0;
  logic [1:0]  m_wen = '0;
  logic [31:0] m_hi = '0, m_lo = '0;
  int unsigned cyc = 0;

  // Observation log used by the directed checks.
  logic [1:0]  pulses[$];
  logic [31:0] last_hi = '0, last_lo = '0;
  int unsigned n_busy = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [65:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          p;
    longint unsigned u;
    int              sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (o)
      3'd0: begin p = longint'(sa) * longint'(sb); return {2'b11, 64'(p)}; end
      3'd1: begin u = 64'(a) * 64'(b); return {2'b11, u}; end
      3'd2: begin
        if (b == 32'd0) return {2'b11, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {2'b11, 32'h0, 32'h8000_0000};
        return {2'b11, 32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 32'd0) return {2'b11, a, 32'hFFFF_FFFF};
        return {2'b11, a % b, a / b};
      end
      3'd4:    return {2'b10, a, 32'h0};
      default: return {2'b01, 32'h0, a};
    endcase
  endfunction

  function automatic int unsigned lat(input logic [2:0] o);
    if (o <= 3'd1) return MUL_LAT;
    if (o <= 3'd3) return 34;
    return 1;
  endfunction

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step(input bit v, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input bit f, input bit rn);
    bit eb, due, acc;
    op_valid = v; op = o; src_a = a; src_b = b; flush = f; resetn = rn;
    #1;
    eb  = m_pend && m_long;
    due = m_pend && (m_due == cyc) && !f;
    check("busy", 64'(busy), 64'(eb));
    check("wen", 64'(wen), due ? 64'(m_wen) : 64'd0);
    if (due && m_wen[1]) check("hiwdata", 64'(hiwdata), 64'(m_hi));
    if (due && m_wen[0]) check("lowdata", 64'(lowdata), 64'(m_lo));
    if (wen != 2'b00) begin
      pulses.push_back(wen);
      last_hi = hiwdata;
      last_lo = lowdata;
    end
    if (busy) n_busy++;
    @(posedge clk);
    acc = rn && v && !eb && !f && (o <= 3'd5);
    if (!rn || f) m_pend = 0;
    else if (m_pend && m_due == cyc) m_pend = 0;
    if (acc) begin
      {m_wen, m_hi, m_lo} = ref_op(o, a, b);
      m_pend = 1;
      m_long = (o <= 3'd3);
      m_due  = cyc + lat(o);
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, 3'd0, 32'd0, 32'd0, 0, 1);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    step(1, o, a, b, 0, 1);
  endtask

  task automatic expect_result(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    check({tag, "_pulses"}, 64'(pulses.size()), 64'd1);
    if (pulses.size() > 0) check({tag, "_wen"}, 64'(pulses[0]), 64'd3);
    check({tag, "_hi"}, 64'(last_hi), 64'(hi));
    check({tag, "_lo"}, 64'(last_lo), 64'(lo));
    pulses.delete();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wen", 64'(wen), 64'd0);
    check("rst_hi", 64'(hiwdata), 64'd0);
    check("rst_lo", 64'(lowdata), 64'd0);

    issue(3'd0, 32'hFFFF_FFFF, 32'd2); idle(4);
    expect_result("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2); idle(4);
    expect_result("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    n_busy = 0;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2); idle(36);
    check("div_busy_cycles", 64'(n_busy), 64'd34);
    expect_result("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(3'd3, 32'd100, 32'd7); idle(36);
    expect_result("divu", 32'd2, 32'd14);
    issue(3'd3, 32'h1234, 32'd0); idle(36);
    expect_result("divu0", 32'h1234, 32'hFFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); idle(36);
    expect_result("div_ovf", 32'h0, 32'h8000_0000);

    // Flush mid-divide, then MTLO right after.
    issue(3'd2, 32'd1000, 32'd3); idle(9);
    step(0, 3'd0, 32'd0, 32'd0, 1, 1);
    check("flush_busy", 64'(busy), 64'd0);
    issue(3'd5, 32'd5, 32'd0); idle(40);
    check("flush_pulses", 64'(pulses.size()), 64'd1);
    if (pulses.size() > 0) check("flush_mtlo_wen", 64'(pulses[0]), 64'd1);
    check("flush_mtlo_lo", 64'(last_lo), 64'd5);
    pulses.delete();

    // op_valid held across the whole busy window: one accept only.
    for (int unsigned i = 0; i <= MUL_LAT; i++) issue(3'd0, 32'd3, 32'd4);
    idle(4);
    expect_result("held", 32'd0, 32'd12);

    issue(3'd4, 32'hA, 32'd0); issue(3'd5, 32'hB, 32'd0); idle(2);
    check("mt_pulses", 64'(pulses.size()), 64'd2);
    if (pulses.size() == 2) begin
      check("mt_first", 64'(pulses[0]), 64'd2);
      check("mt_second", 64'(pulses[1]), 64'd1);
    end
    check("mt_hi", 64'(hiwdata), 64'hA);
    check("mt_lo", 64'(lowdata), 64'hB);
    pulses.delete();

    // Reset in the middle of a divide: no write afterwards, data cleared.
    issue(3'd3, 32'd77, 32'd5); idle(5);
    step(0, 3'd0, 32'd0, 32'd0, 0, 0);
    check("midrst_hi", 64'(hiwdata), 64'd0);
    check("midrst_lo", 64'(lowdata), 64'd0);
    idle(40);
    check("midrst_pulses", 64'(pulses.size()), 64'd0);
    pulses.delete();

    for (int unsigned i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), pick(), pick(),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 499) != 0));
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
